// File: rtl/nios_sysid_pkg.sv
// Shared constants for the system-ID register slave: word map, CAPS layout and
// the legal read-latency range.
package nios_sysid_pkg;

    localparam int unsigned REG_ID      = 0;
    localparam int unsigned REG_TS      = 1;
    localparam int unsigned REG_VER     = 2;
    localparam int unsigned REG_CAPS    = 3;
    localparam int unsigned REG_SCRATCH = 4;
    localparam int unsigned REG_UPLO    = 5;
    localparam int unsigned REG_UPHI    = 6;

    localparam int CAPS_UPTIME_BIT = 0;
    localparam int CAPS_LAT_LSB    = 8;
    localparam int CAPS_AW_LSB     = 16;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int ADDR_W_MIN = 3;

    function automatic logic [31:0] caps_word(input logic uptime, input int lat, input int aw);
        logic [31:0] w;
        w                        = '0;
        w[CAPS_UPTIME_BIT]       = uptime;
        w[CAPS_LAT_LSB +: 8]     = 8'(lat);
        w[CAPS_AW_LSB +: 8]      = 8'(aw);
        return w;
    endfunction

endpackage

// File: rtl/sysid_read_pipe.sv
// Read-response delay line: DEPTH stages of valid + 32-bit data, flushed by
// synchronous reset so no response outlives a reset.
module sysid_read_pipe #(
    parameter int DEPTH = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [31:0] data_i,
    output logic        valid_o,
    output logic [31:0] data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [31:0]      data_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // shifts from its pre-edge neighbour, never from an already-updated one.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            // NOTE: the data stages are reset too, because readdata must read 0
            // whenever readdatavalid is low, including right after reset.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= valid_i ? data_i : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/nios_system_sysid_regs.sv
// Avalon-MM system-ID slave: ID/timestamp/version/caps, R/W scratch word and an
// optional 64-bit uptime counter built only when SYSID_UPTIME_EN is defined.
module nios_system_sysid_regs
    import nios_sysid_pkg::*;
#(
    parameter logic [31:0] SYS_ID       = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter logic [15:0] VER_MAJOR    = 16'd1,
    parameter logic [15:0] VER_MINOR    = 16'd0,
    parameter int          ADDR_W       = 3,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] SCRATCH_INIT = 32'h0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
        $error("nios_system_sysid_regs: READ_LATENCY must be in 1..4");
    end
    if (ADDR_W < ADDR_W_MIN) begin : g_bad_addr_w
        $error("nios_system_sysid_regs: ADDR_W must be >= 3");
    end

`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif
    localparam logic [31:0] CAPS_WORD = caps_word(UPTIME_PRESENT, READ_LATENCY, ADDR_W);

    logic [31:0] addr_ext;
    logic        rd_fire;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] uptime_lo;
    logic [31:0] uptime_hi_snap;
    logic [31:0] rd_data;

    assign addr_ext = 32'(address);
    assign rd_fire  = read && !reset;

    always_comb begin
        scratch_d = scratch_q;
        if (write && addr_ext == REG_SCRATCH) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) scratch_q <= SCRATCH_INIT;
        else       scratch_q <= scratch_d;
    end

`ifdef SYSID_UPTIME_EN
    logic [63:0] uptime_q;
    logic [31:0] hi_snap_q, hi_snap_d;

    // Only a LO read refreshes the snapshot, so HI always pairs with the last LO.
    assign hi_snap_d = (rd_fire && addr_ext == REG_UPLO) ? uptime_q[63:32] : hi_snap_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            uptime_q  <= '0;
            hi_snap_q <= '0;
        end else begin
            uptime_q  <= uptime_q + 64'd1;
            hi_snap_q <= hi_snap_d;
        end
    end

    assign uptime_lo      = uptime_q[31:0];
    assign uptime_hi_snap = hi_snap_q;
`else
    assign uptime_lo      = '0;
    assign uptime_hi_snap = '0;
`endif

    // NOTE: rd_data gets a default before the case so no path infers a latch.
    always_comb begin
        rd_data = '0;
        case (addr_ext)
            REG_ID:      rd_data = SYS_ID;
            REG_TS:      rd_data = TIMESTAMP;
            REG_VER:     rd_data = {VER_MAJOR, VER_MINOR};
            REG_CAPS:    rd_data = CAPS_WORD;
            REG_SCRATCH: rd_data = scratch_q;
            REG_UPLO:    rd_data = uptime_lo;
            REG_UPHI:    rd_data = uptime_hi_snap;
            default:     rd_data = '0;
        endcase
    end

    sysid_read_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_read_pipe (
        .clock   (clock),
        .reset   (reset),
        .valid_i (rd_fire),
        .data_i  (rd_data),
        .valid_o (readdatavalid),
        .data_o  (readdata)
    );

endmodule

// File: tb/tb_nios_system_sysid_regs.sv
// Self-checking bench: two instances (latency 2 and 3), table-driven reads and
// writes with a scoreboard checking data and response cycle.
module tb_nios_system_sysid_regs;

    localparam logic [31:0] A_ID    = 32'h5A1B_2C3D;
    localparam logic [31:0] A_TS    = 32'h6543_2100;
    localparam logic [31:0] A_VER   = 32'h0003_0007;
`ifdef SYSID_UPTIME_EN
    localparam logic [31:0] A_CAPS  = 32'h0003_0201;
`else
    localparam logic [31:0] A_CAPS  = 32'h0003_0200;
`endif
    localparam logic [31:0] B_INIT  = 32'h1234_5678;
    localparam int          A_LAT   = 2;
    localparam int          B_LAT   = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset = 1'b1, a_read = 1'b0, a_write = 1'b0;
    logic [2:0]  a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic [3:0]  a_be = '0;
    logic [31:0] a_rdata;
    logic        a_rdv;

    logic        b_reset = 1'b1, b_read = 1'b0, b_write = 1'b0;
    logic [2:0]  b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [3:0]  b_be = '0;
    logic [31:0] b_rdata;
    logic        b_rdv;

    nios_system_sysid_regs #(
        .SYS_ID(A_ID), .TIMESTAMP(A_TS), .VER_MAJOR(16'd3), .VER_MINOR(16'd7),
        .ADDR_W(3), .READ_LATENCY(A_LAT), .SCRATCH_INIT(32'h0)
    ) dut_a (
        .clock(clk), .reset(a_reset), .address(a_addr), .read(a_read), .write(a_write),
        .writedata(a_wdata), .byteenable(a_be), .readdata(a_rdata), .readdatavalid(a_rdv)
    );

    nios_system_sysid_regs #(
        .SYS_ID(32'hCAFE_0001), .TIMESTAMP(32'h0), .VER_MAJOR(16'd1), .VER_MINOR(16'd0),
        .ADDR_W(3), .READ_LATENCY(B_LAT), .SCRATCH_INIT(B_INIT)
    ) dut_b (
        .clock(clk), .reset(b_reset), .address(b_addr), .read(b_read), .write(b_write),
        .writedata(b_wdata), .byteenable(b_be), .readdata(b_rdata), .readdatavalid(b_rdv)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] alt;
        int          due;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   b_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected readdatavalid expected none", name);
    endtask

    always @(negedge clk) begin
        if (a_rdv === 1'b1) begin
            if (qa.size() == 0) flag("a_unexpected_pulse");
            else begin
                ea = qa.pop_front();
                check({ea.name, "_data"}, a_rdata, (a_rdata === ea.alt) ? ea.alt : ea.exp);
                check({ea.name, "_cycle"}, 32'(cyc), 32'(ea.due));
            end
        end else begin
            check("a_idle_readdata_zero", a_rdata, 32'h0);
        end
    end

    always @(negedge clk) begin
        if (b_rdv === 1'b1) begin
            b_pulses++;
            if (qb.size() == 0) flag("b_unexpected_pulse");
            else begin
                eb = qb.pop_front();
                check({eb.name, "_data"}, b_rdata, eb.exp);
                check({eb.name, "_cycle"}, 32'(cyc), 32'(eb.due));
            end
        end else begin
            check("b_idle_readdata_zero", b_rdata, 32'h0);
        end
    end

    // Drive one cycle on instance A; expectation queued when a read is issued.
    task automatic op_a(input string name, input logic [2:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp, input logic [31:0] alt);
        exp_t e;
        a_addr = addr; a_read = rd; a_write = wr; a_wdata = wd; a_be = be;
        if (rd) begin
            e.name = name; e.exp = exp; e.alt = alt; e.due = cyc + A_LAT;
            qa.push_back(e);
        end
        @(negedge clk);
        a_read = 1'b0; a_write = 1'b0;
    endtask

    task automatic op_b(input string name, input logic [2:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp, input bit expect_resp);
        exp_t e;
        b_addr = addr; b_read = rd; b_write = wr; b_wdata = wd; b_be = be;
        if (rd && expect_resp) begin
            e.name = name; e.exp = exp; e.alt = exp; e.due = cyc + B_LAT;
            qb.push_back(e);
        end
        @(negedge clk);
        b_read = 1'b0; b_write = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        check("drain_a_outstanding", 32'(qa.size()), 32'h0);
        check("drain_b_outstanding", 32'(qb.size()), 32'h0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[16];
    int   pulses_before;

    initial begin
        tbl[0]  = '{"id",            3'd0, 1'b1, 1'b0, 32'h0,         4'h0, A_ID};
        tbl[1]  = '{"timestamp",     3'd1, 1'b1, 1'b0, 32'h0,         4'h0, A_TS};
        tbl[2]  = '{"version",       3'd2, 1'b1, 1'b0, 32'h0,         4'h0, A_VER};
        tbl[3]  = '{"caps",          3'd3, 1'b1, 1'b0, 32'h0,         4'h0, A_CAPS};
        tbl[4]  = '{"b2b_id",        3'd0, 1'b1, 1'b0, 32'h0,         4'h0, A_ID};
        tbl[5]  = '{"b2b_scratch",   3'd4, 1'b1, 1'b0, 32'h0,         4'h0, 32'h0};
        tbl[6]  = '{"b2b_addr7",     3'd7, 1'b1, 1'b0, 32'h0,         4'h0, 32'h0};
        tbl[7]  = '{"b2b_ts",        3'd1, 1'b1, 1'b0, 32'h0,         4'h0, A_TS};
        tbl[8]  = '{"wr_scratch",    3'd4, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0101, 32'h0};
        tbl[9]  = '{"scratch_be",    3'd4, 1'b1, 1'b0, 32'h0,         4'h0, 32'h00AD_00EF};
        tbl[10] = '{"scratch_rw",    3'd4, 1'b1, 1'b1, 32'h1122_3344, 4'hF, 32'h00AD_00EF};
        tbl[11] = '{"scratch_after", 3'd4, 1'b1, 1'b0, 32'h0,         4'h0, 32'h1122_3344};
        tbl[12] = '{"wr_id",         3'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[13] = '{"id_after_wr",   3'd0, 1'b1, 1'b0, 32'h0,         4'h0, A_ID};
        tbl[14] = '{"uphi_initial",  3'd6, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[15] = '{"caps_after_wr", 3'd3, 1'b1, 1'b1, 32'h0,         4'hF, A_CAPS};

        repeat (3) @(negedge clk);
        check("reset_a_rdv", 32'(a_rdv), 32'h0);
        check("reset_a_rdata", a_rdata, 32'h0);
        check("reset_b_rdv", 32'(b_rdv), 32'h0);
        a_reset = 1'b0;
        b_reset = 1'b0;

`ifdef SYSID_UPTIME_EN
        op_a("uptime_first", 3'd5, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
`endif
        for (int i = 0; i < 16; i++) begin
            op_a(tbl[i].name, tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdata, tbl[i].be,
                 tbl[i].exp, tbl[i].exp);
        end
        drain();

`ifdef SYSID_UPTIME_EN
        force dut_a.uptime_q = 64'h0000_0001_FFFF_FFFE;
        op_a("uplo_forced", 3'd5, 1'b1, 1'b0, 32'h0, 4'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        release dut_a.uptime_q;
        op_a("uphi_snap", 3'd6, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1, 32'h1);
        repeat (4) @(negedge clk);
        op_a("uphi_after_wrap", 3'd6, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1, 32'h1);
`else
        op_a("uplo_absent", 3'd5, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        op_a("uphi_absent", 3'd6, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
`endif
        drain();

        op_b("b_wr_scratch", 3'd4, 1'b0, 1'b1, 32'hAAAA_5555, 4'hF, 32'h0, 1'b0);
        op_b("b_scratch_wr", 3'd4, 1'b1, 1'b0, 32'h0, 4'h0, 32'hAAAA_5555, 1'b1);
        drain();

        pulses_before = b_pulses;
        op_b("b_inflight", 3'd4, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        b_reset = 1'b1;
        op_b("b_read_in_reset", 3'd0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        b_reset = 1'b0;
        repeat (8) @(negedge clk);
        check("b_no_late_pulse", 32'(b_pulses - pulses_before), 32'h0);

        op_b("b_scratch_reset", 3'd4, 1'b1, 1'b0, 32'h0, 4'h0, B_INIT, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
